// File: rtl/ibuf_pkg.sv
// Shared types and sizing helpers for the input skew buffer and its register bank.
package ibuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_READY,
        ST_STREAM
    } ibuf_state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_N      = 4;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int stream_len(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int row_w(input int n);
        return clog2_min1(n);
    endfunction

    function automatic int cnt_w(input int n);
        return clog2_min1(n + 1);
    endfunction

    function automatic int step_w(input int n);
        return clog2_min1(stream_len(n));
    endfunction

    localparam int STREAM_LEN  = stream_len(DEF_N);
    localparam int DEF_ROW_W   = row_w(DEF_N);
    localparam int DEF_CNT_W   = cnt_w(DEF_N);
    localparam int DEF_STEP_W  = step_w(DEF_N);

endpackage

// File: rtl/input_skew_buffer_if.sv
// Load/start handshake from the controller and skewed lane outputs toward the MAC array.
interface input_skew_buffer_if #(
    parameter int DATA_W = ibuf_pkg::DEF_DATA_W,
    parameter int N      = ibuf_pkg::DEF_N
);
    logic                load_en;
    logic [N*DATA_W-1:0] load_data;
    logic                start_calc;
    logic [N*DATA_W-1:0] a_out;
    logic [N-1:0]        a_valid;
    logic                full;
    logic                busy;
    logic                err;

    modport master (
        output load_en, load_data, start_calc,
        input  a_out, a_valid, full, busy, err
    );

    modport slave (
        input  load_en, load_data, start_calc,
        output a_out, a_valid, full, busy, err
    );
endinterface

// File: rtl/ibuf_bank.sv
// N x N element register file: one full-row write port, one element read port per row.
module ibuf_bank import ibuf_pkg::*; #(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int N      = DEF_N,
    localparam int ROW_W  = row_w(N)
) (
    input  logic                i_clk,
    input  logic                i_wr_en,
    input  logic [ROW_W-1:0]    i_wr_row,
    input  logic [N*DATA_W-1:0] i_wr_data,
    input  logic [N*ROW_W-1:0]  i_rd_col,
    output logic [N*DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [N][N];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int j = 0; j < N; j++) begin
                r_mem[i_wr_row][j] <= i_wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Read port i is hard-wired to row i; only the column varies.
    for (genvar i = 0; i < N; i++) begin : g_rd
        assign o_rd_data[i*DATA_W +: DATA_W] = r_mem[i][i_rd_col[i*ROW_W +: ROW_W]];
    end
endmodule

// File: rtl/input_skew_buffer.sv
// Captures N operand rows, then replays them as N diagonally skewed lanes.
// Optional macro IBUF_DOUBLE_BUFFER_EN adds a second bank so loading overlaps streaming.
module input_skew_buffer import ibuf_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = DEF_N
) (
    input logic                 i_clk,
    input logic                 i_rst,
    input_skew_buffer_if.slave  bus
);
    localparam int ROW_W  = row_w(N);
    localparam int CNT_W  = cnt_w(N);
    localparam int STEP_W = step_w(N);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(stream_len(N) - 1);
    localparam logic [CNT_W-1:0]  ROWS      = CNT_W'(N);
`ifdef IBUF_DOUBLE_BUFFER_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    ibuf_state_e         r_state;
    ibuf_state_e         w_state_nxt;
    logic [CNT_W-1:0]    r_row_cnt;
    logic [CNT_W-1:0]    w_row_cnt_nxt;
    logic [STEP_W-1:0]   r_step;
    logic [N*DATA_W-1:0] r_a_out;
    logic [N-1:0]        r_a_valid;
    logic                r_full;
    logic                r_busy;
    logic                r_err;

    logic                w_start_acc;
    logic                w_load_acc;
    logic                w_last;
    logic [STEP_W-1:0]   w_diff [N];
    logic [N*ROW_W-1:0]  w_col;
    logic [N-1:0]        w_lane_vld;
    logic [N*DATA_W-1:0] w_rd_data;
    logic [N*DATA_W-1:0] w_lane_data;

    // A start wins over a coincident load; the row counter always tracks the bank being loaded.
    always_comb begin
        w_start_acc   = bus.start_calc && (r_state != ST_STREAM) && (r_row_cnt == ROWS);
        w_load_acc    = bus.load_en && !w_start_acc && (r_row_cnt != ROWS) &&
                        (DBUF || (r_state != ST_STREAM));
        w_last        = (r_state == ST_STREAM) && (r_step == LAST_STEP);

        w_row_cnt_nxt = r_row_cnt;
        if (w_start_acc) begin
            w_row_cnt_nxt = DBUF ? '0 : r_row_cnt;
        end else if (w_load_acc) begin
            w_row_cnt_nxt = r_row_cnt + 1'b1;
        end else if (w_last && !DBUF) begin
            w_row_cnt_nxt = '0;
        end

        w_state_nxt = r_state;
        if (w_start_acc || ((r_state == ST_STREAM) && !w_last)) begin
            w_state_nxt = ST_STREAM;
        end else if (w_row_cnt_nxt == '0) begin
            w_state_nxt = ST_IDLE;
        end else if (w_row_cnt_nxt == ROWS) begin
            w_state_nxt = ST_READY;
        end else begin
            w_state_nxt = ST_FILL;
        end
    end

    // Lane i shows element s-i of row i; the unsigned test keeps s-i from wrapping.
    always_comb begin
        w_col       = '0;
        w_lane_vld  = '0;
        w_lane_data = '0;
        for (int i = 0; i < N; i++) begin
            w_diff[i]                     = r_step - STEP_W'(i);
            w_lane_vld[i]                 = (r_step >= STEP_W'(i)) && (w_diff[i] < STEP_W'(N));
            w_col[i*ROW_W +: ROW_W]       = w_diff[i][ROW_W-1:0];
            w_lane_data[i*DATA_W +: DATA_W] = w_lane_vld[i] ? w_rd_data[i*DATA_W +: DATA_W] : '0;
        end
    end

`ifdef IBUF_DOUBLE_BUFFER_EN
    logic                r_sel;
    logic [N*DATA_W-1:0] w_rd0;
    logic [N*DATA_W-1:0] w_rd1;

    ibuf_bank #(.DATA_W(DATA_W), .N(N)) u_bank0 (
        .i_clk     (i_clk),
        .i_wr_en   (w_load_acc && !r_sel),
        .i_wr_row  (r_row_cnt[ROW_W-1:0]),
        .i_wr_data (bus.load_data),
        .i_rd_col  (w_col),
        .o_rd_data (w_rd0)
    );

    ibuf_bank #(.DATA_W(DATA_W), .N(N)) u_bank1 (
        .i_clk     (i_clk),
        .i_wr_en   (w_load_acc && r_sel),
        .i_wr_row  (r_row_cnt[ROW_W-1:0]),
        .i_wr_data (bus.load_data),
        .i_rd_col  (w_col),
        .o_rd_data (w_rd1)
    );

    // r_sel names the load bank; the stream bank is the other one.
    assign w_rd_data = r_sel ? w_rd0 : w_rd1;
`else
    ibuf_bank #(.DATA_W(DATA_W), .N(N)) u_bank0 (
        .i_clk     (i_clk),
        .i_wr_en   (w_load_acc),
        .i_wr_row  (r_row_cnt[ROW_W-1:0]),
        .i_wr_data (bus.load_data),
        .i_rd_col  (w_col),
        .o_rd_data (w_rd_data)
    );
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_row_cnt <= '0;
            r_step    <= '0;
            r_a_out   <= '0;
            r_a_valid <= '0;
            r_full    <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
`ifdef IBUF_DOUBLE_BUFFER_EN
            r_sel     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_row_cnt <= w_row_cnt_nxt;
            r_full    <= (w_row_cnt_nxt == ROWS);
            r_step    <= ((r_state == ST_STREAM) && !w_last) ? r_step + 1'b1 : '0;
            if ((bus.start_calc && !w_start_acc) || (bus.load_en && !w_load_acc)) begin
                r_err <= 1'b1;
            end
            if (r_state == ST_STREAM) begin
                r_a_out   <= w_lane_data;
                r_a_valid <= w_lane_vld;
                r_busy    <= 1'b1;
            end else begin
                r_a_out   <= '0;
                r_a_valid <= '0;
                r_busy    <= 1'b0;
            end
`ifdef IBUF_DOUBLE_BUFFER_EN
            if (w_start_acc) begin
                r_sel <= ~r_sel;
            end
`endif
        end
    end

    assign bus.a_out   = r_a_out;
    assign bus.a_valid = r_a_valid;
    assign bus.full    = r_full;
    assign bus.busy    = r_busy;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_input_skew_buffer.sv
// Directed bench for input_skew_buffer (N=4, DATA_W=8), both bank configurations.
module tb_input_skew_buffer;
    localparam int DW = 8;
    localparam int NN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    input_skew_buffer_if #(.DATA_W(DW), .N(NN)) bus ();

    input_skew_buffer #(.DATA_W(DW), .N(NN)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_err = 0;
    int n_chk = 0;

    // Expected A_VALID per step, worked out by hand for N=4.
    logic [3:0] vld_tab [7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row r element j = off + 4r + j + 1.
    function automatic logic [31:0] row_val(input int r, input int off);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < NN; j++) v[j*8 +: 8] = 8'(off + 4*r + j + 1);
        return v;
    endfunction

    // Lane i at step s carries row i, column s-i.
    function automatic logic [31:0] lane_exp(input int s, input int off);
        logic [31:0] e;
        e = '0;
        for (int i = 0; i < NN; i++) begin
            if (s >= i && s - i < NN) e[i*8 +: 8] = 8'(off + 4*i + (s - i) + 1);
        end
        return e;
    endfunction

    task automatic do_reset();
        rst            = 1'b1;
        bus.load_en    = 1'b0;
        bus.start_calc = 1'b0;
        bus.load_data  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_row(input int r, input int off);
        bus.load_en   = 1'b1;
        bus.load_data = row_val(r, off);
        tick();
        bus.load_en   = 1'b0;
    endtask

    task automatic fill(input int off);
        for (int r = 0; r < NN; r++) load_row(r, off);
    endtask

    task automatic stream(input int off, input bit with_load, input int load_off,
                          input bit load_during, input int poke_s, input string tag);
        bus.start_calc = 1'b1;
        bus.load_en    = with_load;
        bus.load_data  = 32'hDEADBEEF;
        tick();
        bus.start_calc = 1'b0;
        bus.load_en    = 1'b0;
        chk({tag, ".busy_pre"}, 64'(bus.busy), 64'(0));
        for (int s = 0; s < 7; s++) begin
            bus.load_en    = load_during && (s < NN);
            bus.load_data  = row_val(s % NN, load_off);
            bus.start_calc = (s == poke_s);
            tick();
            chk($sformatf("%s.busy%0d", tag, s), 64'(bus.busy), 64'(1));
            chk($sformatf("%s.vld%0d", tag, s), 64'(bus.a_valid), 64'(vld_tab[s]));
            chk($sformatf("%s.dat%0d", tag, s), 64'(bus.a_out), 64'(lane_exp(s, off)));
        end
        bus.load_en    = 1'b0;
        bus.start_calc = 1'b0;
    endtask

    task automatic end_chk(input string tag);
        tick();
        chk({tag, ".busy_end"}, 64'(bus.busy), 64'(0));
        chk({tag, ".vld_end"}, 64'(bus.a_valid), 64'(0));
        chk({tag, ".dat_end"}, 64'(bus.a_out), 64'(0));
    endtask

    initial begin
        bus.load_en    = 1'b0;
        bus.start_calc = 1'b0;
        bus.load_data  = '0;
        do_reset();
        chk("rst.a_out", 64'(bus.a_out), 64'(0));
        chk("rst.a_valid", 64'(bus.a_valid), 64'(0));
        chk("rst.full", 64'(bus.full), 64'(0));
        chk("rst.busy", 64'(bus.busy), 64'(0));
        chk("rst.err", 64'(bus.err), 64'(0));

        // Basic fill and stream: step 3 must read 0D/0A/07/04 from lane 3 down to lane 0.
        load_row(0, 0);
        load_row(1, 0);
        load_row(2, 0);
        chk("basic.full3", 64'(bus.full), 64'(0));
        load_row(3, 0);
        chk("basic.full4", 64'(bus.full), 64'(1));
        chk("basic.step3_ref", 64'(lane_exp(3, 0)), 64'(32'h0D0A0704));
        stream(0, 1'b0, 0, 1'b0, -1, "basic");
        end_chk("basic");
        chk("basic.full_after", 64'(bus.full), 64'(0));
        chk("basic.err", 64'(bus.err), 64'(0));

        // Premature start after two rows.
        do_reset();
        load_row(0, 8'h20);
        load_row(1, 8'h20);
        bus.start_calc = 1'b1;
        tick();
        bus.start_calc = 1'b0;
        tick();
        chk("prem.busy", 64'(bus.busy), 64'(0));
        chk("prem.err", 64'(bus.err), 64'(1));
        load_row(2, 8'h20);
        load_row(3, 8'h20);
        chk("prem.full", 64'(bus.full), 64'(1));
        stream(8'h20, 1'b0, 0, 1'b0, -1, "prem");
        end_chk("prem");

        // Fifth load is rejected and leaves the bank intact.
        do_reset();
        fill(8'h30);
        load_row(0, 8'h80);
        chk("ovf.err", 64'(bus.err), 64'(1));
        chk("ovf.full", 64'(bus.full), 64'(1));
        stream(8'h30, 1'b0, 0, 1'b0, -1, "ovf");
        end_chk("ovf");

        // Load and start together in READY: start wins, load flagged.
        do_reset();
        fill(8'h50);
        chk("sim.err_pre", 64'(bus.err), 64'(0));
        stream(8'h50, 1'b1, 0, 1'b0, -1, "sim");
        chk("sim.err", 64'(bus.err), 64'(1));
        end_chk("sim");

        // Reset while step 2 is on the outputs.
        do_reset();
        fill(8'h60);
        bus.start_calc = 1'b1;
        tick();
        bus.start_calc = 1'b0;
        tick();
        tick();
        tick();
        chk("rms.vld_step2", 64'(bus.a_valid), 64'(4'h7));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rms.vld", 64'(bus.a_valid), 64'(0));
        chk("rms.busy", 64'(bus.busy), 64'(0));
        chk("rms.full", 64'(bus.full), 64'(0));
        chk("rms.a_out", 64'(bus.a_out), 64'(0));
        fill(8'h70);
        stream(8'h70, 1'b0, 0, 1'b0, -1, "rms");
        end_chk("rms");
        chk("rms.err", 64'(bus.err), 64'(0));

        // Four loads while streaming.
        do_reset();
        fill(8'h90);
        stream(8'h90, 1'b0, 8'hA0, 1'b1, -1, "lds");
`ifdef IBUF_DOUBLE_BUFFER_EN
        chk("lds.full", 64'(bus.full), 64'(1));
        chk("lds.err", 64'(bus.err), 64'(0));
        stream(8'hA0, 1'b0, 0, 1'b0, -1, "b2b");
        end_chk("b2b");
        chk("b2b.full", 64'(bus.full), 64'(0));
        chk("b2b.err", 64'(bus.err), 64'(0));
`else
        end_chk("lds");
        chk("lds.err", 64'(bus.err), 64'(1));
        chk("lds.full", 64'(bus.full), 64'(0));
`endif

        // Start pulse in the middle of a stream.
        do_reset();
        fill(8'hB0);
        stream(8'hB0, 1'b0, 0, 1'b0, 3, "sds");
        end_chk("sds");
        chk("sds.err", 64'(bus.err), 64'(1));
        chk("sds.full", 64'(bus.full), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
